// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters read in ID, trained in EX,
// with one ID->EX prediction register and saturating branch/mispredict counters.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 ID_Branch,
   input  logic [31:0]          ID_pc,
   input  logic                 ID_Flush,
   input  logic                 EX_Flush,
   input  logic                 EX_Branch,
   input  logic [31:0]          EX_pc,
   input  logic                 EX_taken,
   output logic [1:0]           ID_branch_prediction,
   output logic [1:0]           prediction_status,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      ST_MISS_TAKEN    = 2'b00,
      ST_MISS_NOTTAKEN = 2'b01,
      ST_CORRECT       = 2'b10,
      ST_IDLE          = 2'b11
   } status_e;

   logic [1:0]            pht [ENTRIES];
   logic [INDEX_BITS-1:0] id_idx;
   logic [INDEX_BITS-1:0] ex_idx;
   logic                  ex_valid;
   logic [1:0]            ex_pred;
   logic                  resolve;
   logic                  mispredict;
   logic [1:0]            ex_cur;
   logic [1:0]            ex_next;
   status_e               status;

   // Word-aligned PCs: the two low bits and everything above the index are ignored.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{ID_pc[31:INDEX_BITS+2], ID_pc[1:0],
                             EX_pc[31:INDEX_BITS+2], EX_pc[1:0]};

   assign id_idx = ID_pc[INDEX_BITS+1:2];
   assign ex_idx = EX_pc[INDEX_BITS+1:2];

   // Plain array read, so a same-cycle EX write is not visible until the next cycle.
   assign ID_branch_prediction = pht[id_idx];

   assign resolve    = EX_Branch & ex_valid & ~stall;
   assign mispredict = resolve & (ex_pred[1] ^ EX_taken);
   assign ex_cur     = pht[ex_idx];

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      ex_next = ex_cur;
      if (EX_taken) begin
         if (ex_cur != 2'b11) ex_next = ex_cur + 2'b01;
      end else begin
         if (ex_cur != 2'b00) ex_next = ex_cur - 2'b01;
      end
   end

   always_comb begin
      status = ST_IDLE;
      if (resolve) begin
         if (!mispredict)     status = ST_CORRECT;
         else if (ex_pred[1]) status = ST_MISS_NOTTAKEN;
         else                 status = ST_MISS_TAKEN;
      end
   end

   assign prediction_status = status;

   // NOTE: the table is architectural state with a defined reset value, so every
   // entry is reset here rather than left to power-up contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
      end else if (resolve) begin
         pht[ex_idx] <= ex_next;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_pred  <= 2'b01;
      end else if (!stall) begin
         ex_valid <= ID_Branch & ~ID_Flush & ~EX_Flush;
         ex_pred  <= ID_branch_prediction;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (resolve && (branch_count != '1))
            branch_count <= branch_count + 1'b1;
         if (mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: reset sweep, training,
// saturation, stall, same-cycle read/write, flush squashing and mid-run reset.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        ID_Branch;
   logic [31:0] ID_pc;
   logic        ID_Flush;
   logic        EX_Flush;
   logic        EX_Branch;
   logic [31:0] EX_pc;
   logic        EX_taken;
   logic [1:0]  ID_branch_prediction;
   logic [1:0]  prediction_status;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int tests = 0;
   int fails = 0;

   branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .stall                (stall),
      .ID_Branch            (ID_Branch),
      .ID_pc                (ID_pc),
      .ID_Flush             (ID_Flush),
      .EX_Flush             (EX_Flush),
      .EX_Branch            (EX_Branch),
      .EX_pc                (EX_pc),
      .EX_taken             (EX_taken),
      .ID_branch_prediction (ID_branch_prediction),
      .prediction_status    (prediction_status),
      .branch_count         (branch_count),
      .mispredict_count     (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reads the prediction for pc without disturbing any other input.
   task automatic peek(input string tag, input logic [31:0] pc, input logic [1:0] exp);
      ID_pc = pc;
      #1;
      check(tag, {30'd0, ID_branch_prediction}, {30'd0, exp});
   endtask

   task automatic counts(input string tag, input int br, input int mp);
      check({tag, "_branch_count"}, branch_count, br);
      check({tag, "_mispredict_count"}, mispredict_count, mp);
   endtask

   task automatic status(input string tag, input logic [1:0] exp);
      #1;
      check(tag, {30'd0, prediction_status}, {30'd0, exp});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; ID_Branch = 1'b0; ID_pc = '0; ID_Flush = 1'b0;
      EX_Flush = 1'b0; EX_Branch = 1'b0; EX_pc = '0; EX_taken = 1'b0;
      tick();
      rst = 1'b0;

      // 1: reset state sweep
      for (int i = 0; i < 64; i++) peek("reset_pred", 32'(4 * i), 2'b01);
      status("reset_status", 2'b11);
      counts("reset", 0, 0);

      // 2: train 0x40 taken three times
      ID_Branch = 1'b1; ID_pc = 32'h40;
      tick();
      EX_Branch = 1'b1; EX_pc = 32'h40; EX_taken = 1'b1;
      peek("t2_pred0", 32'h40, 2'b01); status("t2_status0", 2'b00);
      tick();
      peek("t2_pred1", 32'h40, 2'b10); status("t2_status1", 2'b00);
      tick();
      peek("t2_pred2", 32'h40, 2'b11); status("t2_status2", 2'b10);
      tick();
      EX_Branch = 1'b0;
      peek("t2_pred3", 32'h40, 2'b11);
      counts("t2", 3, 2);

      // 3: four not-taken resolves from 11 saturate at 00 (ex_pred still 11 here)
      EX_Branch = 1'b1; EX_taken = 1'b0;
      status("t3_status0", 2'b01);
      tick();
      peek("t3_pred1", 32'h40, 2'b10); status("t3_status1", 2'b01);
      tick();
      peek("t3_pred2", 32'h40, 2'b01); status("t3_status2", 2'b01);
      tick();
      peek("t3_pred3", 32'h40, 2'b00); status("t3_status3", 2'b10);
      tick();
      peek("t3_pred4", 32'h40, 2'b00);
      counts("t3", 7, 5);
      ID_Branch = 1'b0; EX_Branch = 1'b0;
      tick();

      // 4: stalled resolve updates exactly once
      ID_Branch = 1'b1; ID_pc = 32'hC0;
      tick();
      ID_Branch = 1'b0; stall = 1'b1;
      EX_Branch = 1'b1; EX_pc = 32'hC0; EX_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         status("t4_stalled_status", 2'b11);
         tick();
      end
      peek("t4_stalled_pred", 32'hC0, 2'b01);
      counts("t4_stalled", 7, 5);
      stall = 1'b0;
      status("t4_release_status", 2'b00);
      tick();
      peek("t4_pred_after", 32'hC0, 2'b10);
      status("t4_status_after", 2'b11);
      tick();
      peek("t4_pred_hold", 32'hC0, 2'b10);
      counts("t4", 8, 6);
      EX_Branch = 1'b0;

      // 5: same-cycle read and write of one index, no bypass
      ID_Branch = 1'b1; ID_pc = 32'h80;
      tick();
      ID_Branch = 1'b0;
      EX_Branch = 1'b1; EX_pc = 32'h80; EX_taken = 1'b1;
      peek("t5_pred_same", 32'h80, 2'b01); status("t5_status", 2'b00);
      tick();
      EX_Branch = 1'b0;
      peek("t5_pred_next", 32'h80, 2'b10);
      counts("t5", 9, 7);

      // 6a: ID_Flush squashes the branch
      ID_Branch = 1'b1; ID_pc = 32'h44; ID_Flush = 1'b1;
      tick();
      ID_Branch = 1'b0; ID_Flush = 1'b0;
      EX_Branch = 1'b1; EX_pc = 32'h44; EX_taken = 1'b1;
      status("t6_idflush_status", 2'b11);
      tick();
      EX_Branch = 1'b0;
      peek("t6_idflush_pred", 32'h44, 2'b01);
      counts("t6_idflush", 9, 7);

      // 6b: EX_Flush squashes the branch
      ID_Branch = 1'b1; ID_pc = 32'h44; EX_Flush = 1'b1;
      tick();
      ID_Branch = 1'b0; EX_Flush = 1'b0;
      EX_Branch = 1'b1; EX_pc = 32'h44; EX_taken = 1'b0;
      status("t6_exflush_status", 2'b11);
      tick();
      EX_Branch = 1'b0;
      peek("t6_exflush_pred", 32'h44, 2'b01);
      counts("t6_exflush", 9, 7);

      // 6c: reset wins over a resolving EX update
      ID_Branch = 1'b1; ID_pc = 32'h44;
      tick();
      ID_Branch = 1'b0;
      EX_Branch = 1'b1; EX_pc = 32'h44; EX_taken = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      status("t6_rst_status", 2'b11);
      peek("t6_rst_pred_44", 32'h44, 2'b01);
      peek("t6_rst_pred_40", 32'h40, 2'b01);
      peek("t6_rst_pred_80", 32'h80, 2'b01);
      peek("t6_rst_pred_C0", 32'hC0, 2'b01);
      counts("t6_rst", 0, 0);
      tick();
      EX_Branch = 1'b0;
      peek("t6_rst_pred_44_hold", 32'h44, 2'b01);
      counts("t6_rst_hold", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
